// File: rtl/arbiter_rr_n.sv
// -----------------------------------------------------------------------------
// arbiter_rr_n
//
// Registered N-requester arbiter with grant locking and a run-time choice
// between fixed-priority and round-robin selection. The grant register holds
// while the current holder keeps requesting. The next grant is issued on the
// same edge that samples the holder's release, so there is no idle cycle
// between holders.
//
// Vectors are declared [0:N-1]. Index 0 is the highest fixed priority.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a holder that has kept the grant for MAXHOLD cycles while
//   another requester waits is forced to yield. When undefined, a holder
//   keeps the grant for as long as it requests, and MAXHOLD is unused.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   r      in   [0:N-1] request vector
//   mode   in   0 = fixed priority, 1 = round-robin
//   g      out  [0:N-1] registered one-hot (or zero) grant
//   gid    out  [IW-1:0] index of the set bit in g, 0 when g is zero
//   valid  out  |g, registered alongside g
// -----------------------------------------------------------------------------
module arbiter_rr_n #(
    parameter int N       = 8,
    parameter int MAXHOLD = 16,
    parameter int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:N-1]  r,
    input  logic          mode,
    output logic [0:N-1]  g,
    output logic [IW-1:0] gid,
    output logic          valid
);

    if (N < 2 || N > 32 || MAXHOLD < 2) begin : g_bad_param
        $error("arbiter_rr_n: illegal parameters N=%0d MAXHOLD=%0d", N, MAXHOLD);
    end

    logic [0:N-1]  g_q, g_d;
    logic [IW-1:0] gid_q, gid_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          holding;
    logic          timeout;
    logic [0:N-1]  cand;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    int            start_idx;
    int            scan_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAXHOLD);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          others_req;
`endif

    // Timeout detection and the candidate set
    always_comb begin
        holding = valid_q & r[gid_q];
`ifdef ARB_TIMEOUT_EN
        others_req = |(r & ~g_q);
        timeout    = holding && (hcnt_q == HW'(MAXHOLD - 1)) && others_req;
`else
        timeout    = 1'b0;
`endif
        // On a forced timeout the holder must not win the re-arbitration.
        cand = timeout ? (r & ~g_q) : r;
    end

    // Selection: circular scan from ptr in round-robin mode, from 0 in fixed
    // mode. Scanning from 0 yields the lowest set index, i.e. the daisy chain.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        start_idx = mode ? int'(ptr_q) : 0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = start_idx + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(scan_idx);
            end
        end
    end

    // Next-state: keep, new grant, or idle
    always_comb begin
        g_d     = g_q;
        gid_d   = gid_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hcnt_d  = '0;
`endif
        if (holding && !timeout) begin
`ifdef ARB_TIMEOUT_EN
            // Reaching the limit with nobody else waiting restarts the count
            // instead of forcing a yield.
            if (hcnt_q == HW'(MAXHOLD - 1)) begin
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
`endif
        end else if (sel_found) begin
            g_d          = '0;
            g_d[sel_idx] = 1'b1;
            gid_d        = sel_idx;
            valid_d      = 1'b1;
            ptr_d        = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);
        end else begin
            g_d     = '0;
            gid_d   = '0;
            valid_d = 1'b0;
        end
    end

    // Grant and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q     <= '0;
            gid_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            g_q     <= g_d;
            gid_q   <= gid_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`endif

    assign g     = g_q;
    assign gid   = gid_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
module tb_arbiter_rr_n;

    localparam int N       = 8;
    localparam int MAXHOLD = 4;
    localparam int IW      = 3;

    logic          clk;
    logic          rst_n;
    logic [0:N-1]  r;
    logic          mode;
    logic [0:N-1]  g;
    logic [IW-1:0] gid;
    logic          valid;

    int total = 0;
    int bad   = 0;

    logic [0:N-1] sb_q [$];

    arbiter_rr_n #(.N(N), .MAXHOLD(MAXHOLD), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .r     (r),
        .mode  (mode),
        .g     (g),
        .gid   (gid),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] exp_gid(input logic [0:N-1] v);
        logic [IW-1:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) res = IW'(i);
        end
        return res;
    endfunction

    // Drive one cycle of stimulus, record the expected grant, and advance
    // to a sampling point 1 time unit after the active edge.
    task automatic tick(input logic [0:N-1] rv, input logic m, input logic [0:N-1] eg);
        r    = rv;
        mode = m;
        sb_q.push_back(eg);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r     = '0;
        mode  = 1'b0;
        #1;
        total++;
        if ({g, gid, valid} !== {8'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: g=%b gid=%0d valid=%b, expected all zero", g, gid, valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        logic [0:N-1] rv [7] = '{8'b00100100, 8'b00000000, 8'b00000011, 8'b00000000,
                                 8'b01010000, 8'b00000000, 8'b00100100};
        logic [0:N-1] eg [7] = '{8'b00100000, 8'b00000000, 8'b00000010, 8'b00000000,
                                 8'b01000000, 8'b00000000, 8'b00100000};
        logic [0:N-1] e;
        for (int i = 0; i < 7; i++) begin
            tick(rv[i], 1'b0, eg[i]);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL fixed[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask

    task automatic test_lock();
        logic [0:N-1] rv [5] = '{8'b00100100, 8'b10100100, 8'b10000100, 8'b10000100, 8'b00000100};
        logic [0:N-1] eg [5] = '{8'b00100000, 8'b00100000, 8'b10000000, 8'b10000000, 8'b00000100};
        logic [0:N-1] e;
        for (int i = 0; i < 5; i++) begin
            tick(rv[i], 1'b0, eg[i]);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL lock[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask

    task automatic test_rr_rotation();
        logic [0:N-1] rv;
        logic [0:N-1] eg;
        logic [0:N-1] e;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            rv = '1;
            if (i > 0) rv[(i - 1) % N] = 1'b0;
            eg = '0;
            eg[i % N] = 1'b1;
            tick(rv, 1'b1, eg);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL rr_rotation[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [0:N-1] rv [7] = '{8'b00100000, 8'b10000010, 8'b11000001, 8'b11000000,
                                 8'b01000000, 8'b11000000, 8'b10000000};
        logic         md [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [0:N-1] eg [7] = '{8'b00100000, 8'b00000010, 8'b00000001, 8'b10000000,
                                 8'b01000000, 8'b01000000, 8'b10000000};
        logic [0:N-1] e;
        for (int i = 0; i < 7; i++) begin
            tick(rv[i], md[i], eg[i]);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL rr_skip[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask

    task automatic test_empty_async();
        logic [0:N-1] rv [3] = '{8'b00000000, 8'b00010000, 8'b00010000};
        logic [0:N-1] eg [3] = '{8'b00000000, 8'b00010000, 8'b00010000};
        logic [0:N-1] e;
        for (int i = 0; i < 3; i++) begin
            tick(rv[i], 1'b0, eg[i]);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL empty_lock[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
        // Reset between edges while index 3 holds the grant.
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({g, gid, valid} !== {8'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: g=%b gid=%0d valid=%b, expected all zero", g, gid, valid);
        end
        #1;
        rst_n = 1'b1;
        // Pointer must restart at 0: index 0 wins, not index 7.
        tick(8'b10000001, 1'b1, 8'b10000000);
        e = sb_q.pop_front();
        total++;
        if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
            bad++;
            $display("FAIL ptr_restart: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                     g, gid, valid, e, exp_gid(e), |e);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [0:N-1] e;
        logic [0:N-1] eg;
        logic [0:N-1] seq [9] = '{8'b10000000, 8'b10000000, 8'b10000000, 8'b10000000,
                                  8'b01000000, 8'b01000000, 8'b01000000, 8'b01000000,
                                  8'b10000000};
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                tick(8'b00000000, 1'b0, 8'b00000000);
            end else if (i <= 9) begin
                tick(8'b11000000, 1'b0, seq[i - 1]);
            end else begin
                eg = 8'b10000000;
                tick(8'b10000000, 1'b0, eg);
            end
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL timeout[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [0:N-1] e;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) tick(8'b00000000, 1'b0, 8'b00000000);
            else        tick(8'b11000000, 1'b0, 8'b10000000);
            e = sb_q.pop_front();
            total++;
            if ({g, gid, valid} !== {e, exp_gid(e), |e}) begin
                bad++;
                $display("FAIL hold_forever[%0d]: g=%b gid=%0d valid=%b, expected g=%b gid=%0d valid=%b",
                         i, g, gid, valid, e, exp_gid(e), |e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_lock();
        test_rr_rotation();
        test_rr_skip();
        test_empty_async();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
